// File: rtl/mcc_adder_arbiter.sv
// Round-robin arbiter sharing one Manchester-carry-chain adder between NUM_REQ requesters.
// Optional registered signed-overflow output rsp_ovf when MCC_ARB_OVF_EN is defined.

module mcc_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum  = prop ^ carry[N-1:0];
        cout = carry[N];
    end
endmodule

module mcc_adder_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N-1:0]         rsp_sum,
    output logic                 rsp_cout
`ifdef MCC_ARB_OVF_EN
    ,
    output logic                 rsp_ovf
`endif
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;

    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] grant_hi;
    logic [ID_W-1:0] grant_lo;
    logic            found_hi;
    logic            found_lo;
    logic            can_accept;
    logic            accept;
    logic [N-1:0]    a_sel;
    logic [N-1:0]    b_sel;
    logic            cin_sel;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    // Rotating priority: lowest valid index at or above rr_ptr wins, else lowest valid overall.
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req_valid[i-1]) begin
                grant_lo = ID_W'(i-1);
                found_lo = 1'b1;
                if ((i - 1) >= 32'(rr_ptr_q)) begin
                    grant_hi = ID_W'(i-1);
                    found_hi = 1'b1;
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
    end

    always_comb begin
        can_accept = (state_q == EMPTY) | rsp_ready;
        req_ready  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant) begin
                req_ready[i] = found_lo & can_accept & ~rst;
            end
        end
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant) begin
                a_sel   = req_a[i*N +: N];
                b_sel   = req_b[i*N +: N];
                cin_sel = req_cin[i];
            end
        end
    end

    mcc_adder #(.N(N)) u_adder (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        if (accept) begin
            state_d    = FULL;
            rsp_id_d   = grant;
            rsp_sum_d  = add_sum;
            rsp_cout_d = add_cout;
            rr_ptr_d   = (32'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef MCC_ARB_OVF_EN
    logic rsp_ovf_q, rsp_ovf_d;

    always_comb begin
        rsp_ovf_d = rsp_ovf_q;
        if (accept) begin
            rsp_ovf_d = (a_sel[N-1] ~^ b_sel[N-1]) & (add_sum[N-1] ^ a_sel[N-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf_q <= 1'b0;
        end else begin
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`endif
endmodule

// File: tb/tb_mcc_adder_arbiter.sv
// Directed self-checking bench for mcc_adder_arbiter (N=8, NUM_REQ=4).
// Overflow checks are compiled in when MCC_ARB_OVF_EN is defined.

module tb_mcc_adder_arbiter;
    localparam int unsigned N       = 8;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic [NUM_REQ-1:0]   req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [N-1:0]         rsp_sum;
    logic                 rsp_cout;
`ifdef MCC_ARB_OVF_EN
    logic                 rsp_ovf;
`endif

    int asserts = 0;
    int fails   = 0;

    mcc_adder_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef MCC_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_cin[i]      = c;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_cin = '0;
        @(negedge clk);
        asserts++; if (req_ready !== 4'b0000) begin $display("FAIL reset_ready got %b exp %b", req_ready, 4'b0000); fails++; end
        tick();
        asserts++; if (rsp_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", rsp_valid); fails++; end
        asserts++; if (rsp_sum !== 8'h00) begin $display("FAIL reset_sum got %h exp 00", rsp_sum); fails++; end
        asserts++; if (rsp_id !== 2'd0) begin $display("FAIL reset_id got %0d exp 0", rsp_id); fails++; end
        asserts++; if (rsp_cout !== 1'b0) begin $display("FAIL reset_cout got %b exp 0", rsp_cout); fails++; end
`ifdef MCC_ARB_OVF_EN
        asserts++; if (rsp_ovf !== 1'b0) begin $display("FAIL reset_ovf got %b exp 0", rsp_ovf); fails++; end
`endif
        rst = 1'b0; req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_result();
        rsp_ready = 1'b0;
        set_req(1, 8'h12, 8'h34, 1'b0);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        asserts++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h46) begin $display("FAIL midrst_fill got v=%b sum=%h exp v=1 sum=46", rsp_valid, rsp_sum); fails++; end
        rst = 1'b1; req_valid = 4'b0100;
        #1;
        asserts++; if (req_ready !== 4'b0000) begin $display("FAIL midrst_ready got %b exp 0000", req_ready); fails++; end
        tick();
        rst = 1'b0; req_valid = 4'b0000;
        #1;
        asserts++; if (rsp_valid !== 1'b0) begin $display("FAIL midrst_valid got %b exp 0", rsp_valid); fails++; end
        asserts++; if (rsp_sum !== 8'h00 || rsp_id !== 2'd0) begin $display("FAIL midrst_regs got sum=%h id=%0d exp sum=00 id=0", rsp_sum, rsp_id); fails++; end
        req_valid = 4'b1111;
        #1;
        asserts++; if (req_ready !== 4'b0001) begin $display("FAIL midrst_ptr got %b exp 0001", req_ready); fails++; end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(1, 8'h7F, 8'h01, 1'b0);
        req_valid = 4'b0010;
        #1;
        asserts++; if (req_ready !== 4'b0010) begin $display("FAIL single_ready got %b exp 0010", req_ready); fails++; end
        tick();
        req_valid = 4'b0000;
        asserts++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin $display("FAIL single_vid got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); fails++; end
        asserts++; if (rsp_sum !== 8'h80 || rsp_cout !== 1'b0) begin $display("FAIL single_sum got %b_%h exp 0_80", rsp_cout, rsp_sum); fails++; end
`ifdef MCC_ARB_OVF_EN
        asserts++; if (rsp_ovf !== 1'b1) begin $display("FAIL single_ovf got %b exp 1", rsp_ovf); fails++; end
`endif
        tick();
        asserts++; if (rsp_valid !== 1'b0) begin $display("FAIL single_drain got %b exp 0", rsp_valid); fails++; end
    endtask

    // rr_ptr is 2 here; requester 0 is reached by wrapping.
    task automatic test_carry();
        rsp_ready = 1'b1;
        set_req(0, 8'hFF, 8'h01, 1'b1);
        req_valid = 4'b0001;
        #1;
        asserts++; if (req_ready !== 4'b0001) begin $display("FAIL carry_ready got %b exp 0001", req_ready); fails++; end
        tick();
        req_valid = 4'b0000;
        asserts++; if (rsp_sum !== 8'h01 || rsp_cout !== 1'b1 || rsp_id !== 2'd0) begin $display("FAIL carry_rsp got id=%0d %b_%h exp id=0 1_01", rsp_id, rsp_cout, rsp_sum); fails++; end
`ifdef MCC_ARB_OVF_EN
        asserts++; if (rsp_ovf !== 1'b0) begin $display("FAIL carry_ovf got %b exp 0", rsp_ovf); fails++; end
`endif
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_sum [4] = '{8'h01, 8'h13, 8'h23, 8'h35};
        int         exp_id  [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_rdy;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 8'(16 * i + 1), 8'(i), 1'(i % 2));
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << exp_id[k];
            asserts++; if (req_ready !== exp_rdy) begin $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); fails++; end
            tick();
            asserts++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[k]) || rsp_sum !== exp_sum[exp_id[k]]) begin
                $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h", k, rsp_valid, rsp_id, rsp_sum, exp_id[k], exp_sum[exp_id[k]]); fails++;
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    // rr_ptr is 1 on entry.
    task automatic test_back_to_back_backpressure();
        rsp_ready = 1'b0;
        set_req(2, 8'h40, 8'h40, 1'b0);
        req_valid = 4'b0100;
        tick();
        set_req(2, 8'h05, 8'h06, 1'b1);
        for (int k = 0; k < 3; k++) begin
            asserts++; if (req_ready !== 4'b0000) begin $display("FAIL bp_ready[%0d] got %b exp 0000", k, req_ready); fails++; end
            asserts++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h80 || rsp_id !== 2'd2 || rsp_cout !== 1'b0) begin
                $display("FAIL bp_hold[%0d] got v=%b id=%0d %b_%h exp v=1 id=2 0_80", k, rsp_valid, rsp_id, rsp_cout, rsp_sum); fails++;
            end
`ifdef MCC_ARB_OVF_EN
            asserts++; if (rsp_ovf !== 1'b1) begin $display("FAIL bp_ovf[%0d] got %b exp 1", k, rsp_ovf); fails++; end
`endif
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        asserts++; if (req_ready !== 4'b0100) begin $display("FAIL bp_release got %b exp 0100", req_ready); fails++; end
        tick();
        req_valid = 4'b0000;
        asserts++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h0C || rsp_id !== 2'd2 || rsp_cout !== 1'b0) begin
            $display("FAIL bp_next got v=%b id=%0d %b_%h exp v=1 id=2 0_0c", rsp_valid, rsp_id, rsp_cout, rsp_sum); fails++;
        end
        tick();
    endtask

    // rr_ptr is 3 on entry.
    task automatic test_wrap_skip();
        rsp_ready = 1'b1;
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(2, 8'h80, 8'h80, 1'b0);
        req_valid = 4'b0101;
        #1;
        asserts++; if (req_ready !== 4'b0001) begin $display("FAIL wrap_first got %b exp 0001", req_ready); fails++; end
        tick();
        asserts++; if (rsp_id !== 2'd0 || rsp_sum !== 8'h03) begin $display("FAIL wrap_rsp0 got id=%0d sum=%h exp id=0 sum=03", rsp_id, rsp_sum); fails++; end
        asserts++; if (req_ready !== 4'b0100) begin $display("FAIL wrap_second got %b exp 0100", req_ready); fails++; end
        tick();
        req_valid = 4'b0000;
        asserts++; if (rsp_id !== 2'd2 || rsp_sum !== 8'h00 || rsp_cout !== 1'b1) begin $display("FAIL wrap_rsp2 got id=%0d %b_%h exp id=2 1_00", rsp_id, rsp_cout, rsp_sum); fails++; end
`ifdef MCC_ARB_OVF_EN
        asserts++; if (rsp_ovf !== 1'b1) begin $display("FAIL wrap_ovf got %b exp 1", rsp_ovf); fails++; end
`endif
        tick();
        asserts++; if (rsp_valid !== 1'b0) begin $display("FAIL wrap_drain got %b exp 0", rsp_valid); fails++; end
    endtask

    initial begin
        test_reset();
        test_reset_mid_result();
        test_single();
        test_carry();
        test_round_robin();
        test_back_to_back_backpressure();
        test_wrap_skip();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
